// File: rtl/sim_clock_monitor.sv
`default_nettype none
// ============================================================================
// Module  : sim_clock_monitor
// Brief   : Measures the period of the slow simulation clock in clk_50Mhz
//           cycles and reports lock/loss. Optional duty-cycle check is
//           enabled by defining SIM_CLOCK_MONITOR_DUTY_CHECK_EN.
// Revision: 1.0
// ============================================================================
module sim_clock_monitor #(
  parameter int EXPECTED_PERIOD = 252,
  parameter int TOLERANCE       = 2,
  parameter int LOCK_COUNT      = 4,
  parameter int TIMEOUT         = 1023
) (
  input  logic        clk_50Mhz,
  input  logic        reset_n,
  input  logic        clk_in,
  output logic [15:0] period_count,
  output logic        period_valid,
  output logic        locked,
  output logic        lost,
  output logic [7:0]  error_count,
  output logic        duty_err
);

  localparam int GW = $clog2(LOCK_COUNT + 1);

  localparam logic [15:0]   c_timeout  = 16'(TIMEOUT);
  localparam logic [15:0]   c_per_min  = 16'(EXPECTED_PERIOD - TOLERANCE);
  localparam logic [15:0]   c_per_max  = 16'(EXPECTED_PERIOD + TOLERANCE);
  localparam logic [GW-1:0] c_lock     = GW'(LOCK_COUNT);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACQUIRE = 2'd1,
    S_LOCKED  = 2'd2,
    S_LOST    = 2'd3
  } state_t;

  logic          r_sync1;
  logic          r_sync2;
  logic          r_prev;
  logic [15:0]   r_cnt;
  state_t        r_state;
  state_t        w_state_nxt;
  logic [GW-1:0] r_good_cnt;
  logic [GW-1:0] w_good_nxt;
  logic [GW-1:0] w_good_inc;
  logic          w_rise;
  logic          w_fall;
  logic          w_timeout;
  logic          w_in_tol;
  logic          w_period_good;
  logic          w_capture;
  logic          w_bad;
  logic          w_duty_fail;

  assign w_rise     = r_sync2 & ~r_prev;
  assign w_fall     = ~r_sync2 & r_prev;
  // A rise on the same cycle as the timeout wins, so the period is still measured.
  assign w_timeout  = ~w_rise & (r_cnt == (c_timeout - 16'd1));
  assign w_in_tol   = (r_cnt >= c_per_min) && (r_cnt <= c_per_max);
  assign w_good_inc = r_good_cnt + 1'b1;
  assign w_period_good = w_in_tol & ~((r_state == S_LOCKED) & w_duty_fail);

  always_comb begin
    w_state_nxt = r_state;
    w_good_nxt  = r_good_cnt;
    w_capture   = 1'b0;
    w_bad       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_rise) begin
          w_state_nxt = S_ACQUIRE;
          w_good_nxt  = '0;
        end else if (w_timeout) begin
          w_state_nxt = S_LOST;
        end
      end
      S_ACQUIRE: begin
        if (w_rise) begin
          w_capture = 1'b1;
          if (w_period_good) begin
            if (w_good_inc >= c_lock) begin
              w_state_nxt = S_LOCKED;
              w_good_nxt  = c_lock;
            end else begin
              w_good_nxt  = w_good_inc;
            end
          end else begin
            w_good_nxt = '0;
            w_bad      = 1'b1;
          end
        end else if (w_timeout) begin
          w_state_nxt = S_LOST;
        end
      end
      S_LOCKED: begin
        if (w_rise) begin
          w_capture = 1'b1;
          if (!w_period_good) begin
            w_state_nxt = S_ACQUIRE;
            w_good_nxt  = '0;
            w_bad       = 1'b1;
          end
        end else if (w_timeout) begin
          w_state_nxt = S_LOST;
        end
      end
      S_LOST: begin
        // The partial period straddling the recovery is not measured.
        if (w_rise) begin
          w_state_nxt = S_ACQUIRE;
          w_good_nxt  = '0;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_50Mhz) begin
    if (!reset_n) begin
      r_sync1      <= 1'b0;
      r_sync2      <= 1'b0;
      r_prev       <= 1'b0;
      r_cnt        <= '0;
      r_state      <= S_IDLE;
      r_good_cnt   <= '0;
      period_count <= '0;
      period_valid <= 1'b0;
      locked       <= 1'b0;
      lost         <= 1'b0;
      error_count  <= '0;
    end else begin
      r_sync1 <= clk_in;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      if (w_rise) begin
        r_cnt <= 16'd1;
      end else if (r_cnt != c_timeout) begin
        r_cnt <= r_cnt + 16'd1;
      end
      r_state      <= w_state_nxt;
      r_good_cnt   <= w_good_nxt;
      period_valid <= w_capture;
      if (w_capture) begin
        period_count <= r_cnt;
      end
      locked <= (w_state_nxt == S_LOCKED);
      lost   <= (w_state_nxt == S_LOST);
      if (w_bad && (error_count != 8'hFF)) begin
        error_count <= error_count + 8'd1;
      end
    end
  end

`ifdef SIM_CLOCK_MONITOR_DUTY_CHECK_EN
  localparam logic [15:0] c_hi_min = 16'((EXPECTED_PERIOD / 2) - TOLERANCE);
  localparam logic [15:0] c_hi_max = 16'((EXPECTED_PERIOD / 2) + TOLERANCE);

  logic [15:0] r_hi_cnt;

  // High time counts the rise cycle itself, so a symmetric input yields period/2.
  always_ff @(posedge clk_50Mhz) begin
    if (!reset_n) begin
      r_hi_cnt <= '0;
      duty_err <= 1'b0;
    end else begin
      if (w_rise) begin
        r_hi_cnt <= 16'd1;
      end else if (r_sync2 && (r_hi_cnt != 16'hFFFF)) begin
        r_hi_cnt <= r_hi_cnt + 16'd1;
      end
      if (w_fall) begin
        duty_err <= (r_hi_cnt < c_hi_min) || (r_hi_cnt > c_hi_max);
      end
    end
  end

  assign w_duty_fail = duty_err;
`else
  assign duty_err    = 1'b0;
  assign w_duty_fail = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sim_clock_monitor.sv
`default_nettype none
// ============================================================================
// Module  : tb_sim_clock_monitor
// Brief   : Directed self-checking bench for sim_clock_monitor.
// Revision: 1.0
// ============================================================================
module tb_sim_clock_monitor;

  logic        clk;
  logic        reset_n;
  logic        clk_in;
  logic [15:0] period_count;
  logic        period_valid;
  logic        locked;
  logic        lost;
  logic [7:0]  error_count;
  logic        duty_err;

  int checks = 0;
  int errors = 0;
  int pv_cnt = 0;
  int pv0;

`ifdef SIM_CLOCK_MONITOR_DUTY_CHECK_EN
  localparam logic c_duty = 1'b1;
`else
  localparam logic c_duty = 1'b0;
`endif

  sim_clock_monitor dut (
    .clk_50Mhz    (clk),
    .reset_n      (reset_n),
    .clk_in       (clk_in),
    .period_count (period_count),
    .period_valid (period_valid),
    .locked       (locked),
    .lost         (lost),
    .error_count  (error_count),
    .duty_err     (duty_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (period_valid) pv_cnt <= pv_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clk_in cycle: h cycles high then l cycles low, edges on clk negedges.
  task automatic pulse(input int h, input int l);
    clk_in = 1'b1;
    repeat (h) @(negedge clk);
    clk_in = 1'b0;
    repeat (l) @(negedge clk);
  endtask

  initial begin
    reset_n = 1'b0;
    clk_in  = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_period_count", 32'(period_count), 0);
    check("rst_period_valid", 32'(period_valid), 0);
    check("rst_locked", 32'(locked), 0);
    check("rst_lost", 32'(lost), 0);
    check("rst_error_count", 32'(error_count), 0);
    check("rst_duty_err", 32'(duty_err), 0);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);

    // Initial acquisition: 1 rise to enter ACQUIRE, 4 good periods to lock
    repeat (4) pulse(126, 126);
    check("acq_not_locked_yet", 32'(locked), 0);
    pulse(126, 126);
    check("acq_locked", 32'(locked), 1);
    check("acq_lost", 32'(lost), 0);
    check("acq_period_count", 32'(period_count), 252);
    check("acq_error_count", 32'(error_count), 0);
    check("acq_pv_pulses", 32'(pv_cnt), 4);
    check("acq_duty_err", 32'(duty_err), 0);

    // One 260-cycle period drops lock on the cycle after the rise
    pulse(130, 130);
    clk_in = 1'b1;
    repeat (2) @(negedge clk);
    check("p260_locked_before", 32'(locked), 1);
    check("p260_pv_before", 32'(period_valid), 0);
    @(negedge clk);
    check("p260_locked_after", 32'(locked), 0);
    check("p260_pv_pulse", 32'(period_valid), 1);
    check("p260_period_count", 32'(period_count), 260);
    repeat (123) @(negedge clk);
    clk_in = 1'b0;
    repeat (126) @(negedge clk);
    check("p260_error_count", 32'(error_count), 1);
    repeat (3) pulse(126, 126);
    check("p260_relock_3", 32'(locked), 0);
    pulse(126, 126);
    check("p260_relock_4", 32'(locked), 1);

    // Tolerance boundaries
    pulse(125, 125);
    pulse(127, 127);
    check("b250_period", 32'(period_count), 250);
    check("b250_locked", 32'(locked), 1);
    pulse(126, 126);
    check("b254_period", 32'(period_count), 254);
    check("b254_locked", 32'(locked), 1);
    check("b254_errors", 32'(error_count), 1);
    pulse(125, 124);
    pulse(126, 126);
    check("b249_period", 32'(period_count), 249);
    check("b249_locked", 32'(locked), 0);
    check("b249_errors", 32'(error_count), 2);
    pulse(128, 127);
    pulse(126, 126);
    check("b255_period", 32'(period_count), 255);
    check("b255_errors", 32'(error_count), 3);
    repeat (4) pulse(126, 126);
    check("b_relock", 32'(locked), 1);

    // Loss: clk_in held low after a rise; cnt hits 1023 at the 1025th edge
    clk_in = 1'b1;
    repeat (3) @(negedge clk);
    repeat (123) @(negedge clk);
    clk_in = 1'b0;
    repeat (898) @(negedge clk);
    check("loss_lost_before", 32'(lost), 0);
    check("loss_locked_before", 32'(locked), 1);
    @(negedge clk);
    check("loss_lost", 32'(lost), 1);
    check("loss_locked", 32'(locked), 0);
    check("loss_errors", 32'(error_count), 3);
    repeat (20) @(negedge clk);

    // Recovery: first rise only re-arms, then 4 good periods
    pv0 = pv_cnt;
    pulse(126, 126);
    check("rec_lost_cleared", 32'(lost), 0);
    check("rec_not_locked", 32'(locked), 0);
    check("rec_no_capture", 32'(pv_cnt), 32'(pv0));
    repeat (3) pulse(126, 126);
    check("rec_locked_3", 32'(locked), 0);
    pulse(126, 126);
    check("rec_locked_4", 32'(locked), 1);
    check("rec_errors", 32'(error_count), 3);
    check("rec_pv_pulses", 32'(pv_cnt), 32'(pv0 + 4));

    // Reset pulse mid-period while locked
    clk_in = 1'b1;
    repeat (126) @(negedge clk);
    clk_in = 1'b0;
    repeat (60) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    check("mrst_period_count", 32'(period_count), 0);
    check("mrst_period_valid", 32'(period_valid), 0);
    check("mrst_locked", 32'(locked), 0);
    check("mrst_lost", 32'(lost), 0);
    check("mrst_errors", 32'(error_count), 0);
    check("mrst_duty_err", 32'(duty_err), 0);
    reset_n = 1'b1;
    repeat (65) @(negedge clk);
    pv0 = pv_cnt;
    pulse(126, 126);
    check("mrst_idle_no_capture", 32'(pv_cnt), 32'(pv0));
    check("mrst_idle_errors", 32'(error_count), 0);
    check("mrst_idle_period", 32'(period_count), 0);
    repeat (4) pulse(126, 126);
    check("mrst_relock", 32'(locked), 1);
    check("mrst_relock_period", 32'(period_count), 252);
    check("mrst_relock_errors", 32'(error_count), 0);

    // Error counter saturation with 20-cycle periods
    repeat (100) pulse(10, 10);
    check("sat_errors_99", 32'(error_count), 99);
    check("sat_period_20", 32'(period_count), 20);
    repeat (200) pulse(10, 10);
    check("sat_errors_255", 32'(error_count), 255);
    pulse(126, 126);
    check("sat_hold_255", 32'(error_count), 255);
    repeat (4) pulse(126, 126);
    check("sat_relock", 32'(locked), 1);
    check("sat_relock_period", 32'(period_count), 252);

    // Duty-cycle: 252 period with 100 high cycles
    pulse(100, 152);
    check("duty_flag", 32'(duty_err), 32'(c_duty));
    check("duty_locked_pre", 32'(locked), 1);
    pulse(126, 126);
    check("duty_locked_post", 32'(locked), 32'(!c_duty));
    check("duty_flag_cleared", 32'(duty_err), 0);
    check("duty_period", 32'(period_count), 252);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sim_clock_monitor.md
Name: sim_clock_monitor

Overview:
- Receive-side counterpart of the simulation clock divider. Samples a slow simulation clock, nominally 200 kHz, in the clk_50Mhz domain.
- Measures each period in 50 MHz cycles and declares lock or loss of the clock.
- Used in the HIL fabric to qualify the simulation clock before downstream sim logic is enabled, and to flag divider or fabric faults.

Parameters:
- EXPECTED_PERIOD, 252, nominal period of clk_in in clk_50Mhz cycles.
- TOLERANCE, 2, allowed ± deviation in cycles for a period to count as good.
- LOCK_COUNT, 4, consecutive good periods required to enter LOCKED.
- TIMEOUT, 1023, cycles without a clk_in rising edge before declaring loss; must be below 65535.

Ports:
- clk_50Mhz  input  1  system clock; all logic on its rising edge.
- reset_n  input  1  synchronous, active-low reset.
- clk_in  input  1  monitored slow clock; asynchronous to clk_50Mhz.
- period_count  output  16  last measured full period, in cycles.
- period_valid  output  1  one-cycle pulse when period_count updates.
- locked  output  1  high while in the LOCKED state.
- lost  output  1  high while in the LOST state.
- error_count  output  8  count of out-of-tolerance periods; saturates at 255.
- duty_err  output  1  duty-cycle fault flag (see Optional Feature).

Behaviour:
- Reset:
  - Interface: one clock, clk_50Mhz; reset_n is synchronous and active-low.
  - While reset_n=0 at a clock edge, all state clears.
  - period_count=0, period_valid=0, locked=0, lost=0, error_count=0, duty_err=0.
  - Synchronizer flops and cycle counter go to 0; FSM goes to IDLE.
  - Reset asserted mid-measurement discards the partial period; no period_valid is produced.
- Input path:
  - clk_in passes through a 2-flop synchronizer, then a third flop for edge detection.
  - rise = sync & ~prev.
  - Latency from a clk_in transition to rise is 3 clk_50Mhz edges.
- Cycle counter (cnt, 16-bit):
  - On rise: cnt<=1.
  - Otherwise: cnt<=cnt+1, saturating at TIMEOUT.
- Period capture:
  - On rise in any state other than IDLE and LOST: period_count<=cnt and period_valid=1 for that cycle.
  - A period is good when EXPECTED_PERIOD−TOLERANCE ≤ cnt ≤ EXPECTED_PERIOD+TOLERANCE (inclusive).
  - Comparison uses the pre-update cnt value.
- FSM states: IDLE, ACQUIRE, LOCKED, LOST.
  - IDLE:
    - rise → ACQUIRE, good_cnt=0, no capture.
    - cnt reaching TIMEOUT → LOST.
  - ACQUIRE:
    - Good period: good_cnt++.
    - When good_cnt reaches LOCK_COUNT on that rise → LOCKED.
    - Bad period: good_cnt=0, error_count++.
    - Timeout → LOST.
  - LOCKED:
    - Good period: stay.
    - Bad period → ACQUIRE, good_cnt=0, error_count++.
    - Timeout → LOST; error_count is not incremented.
  - LOST:
    - rise → ACQUIRE, good_cnt=0, no capture; the first partial period after loss is not measured.
- Outputs are registered state decodes: locked==(state==LOCKED), lost==(state==LOST).
- Timeout fires on the cycle cnt transitions to TIMEOUT.
  - If rise occurs on that same cycle, rise wins: capture and classify normally, no LOST entry.
- error_count holds at 255 and does not wrap.
- good_cnt width is sized for LOCK_COUNT and does not increment past LOCK_COUNT.

Optional Feature:
- Macro: SIM_CLOCK_MONITOR_DUTY_CHECK_EN.
- When defined:
  - A high-time counter records cycles with sync=1 since the last rise, captured at the falling edge of sync.
  - On each capture, duty_err<=1 if high time lies outside EXPECTED_PERIOD/2 ± TOLERANCE; otherwise duty_err<=0.
  - A duty failure in LOCKED counts as a bad period at the next rise: error_count++ and → ACQUIRE.
- When undefined:
  - duty_err is tied 0, no high-time logic is built, and classification uses period only.

Test Plan:
- Reset, then clk_in toggling every 126 cycles (period 252): first rise → ACQUIRE. After 4 good periods → locked=1, period_count=252, period_valid pulses once per period, error_count=0.
- Locked, then one period of 260 → period_count=260, locked drops the cycle after the rise, error_count=1. Four further 252 periods → locked=1 again.
- Locked, then clk_in held low → lost=1 exactly 1023 cycles after the last rise, locked=0. clk_in resumes at 252 → ACQUIRE, relock after 1+4 rises.
- Boundary periods of 250 and 254 are classified good; 249 and 255 increment error_count. 300 bad periods → error_count saturates at 255.
- reset_n asserted for one cycle mid-period while locked → all outputs 0 the next cycle, no period_valid, FSM re-enters IDLE.
- With SIM_CLOCK_MONITOR_DUTY_CHECK_EN defined, period 252 with high time 100 → duty_err=1 and exit from LOCKED. Without the macro, the same stimulus keeps locked=1 and duty_err=0.
